// File: rtl/alu_mc_if.sv
// alu_mc_if -- operand/result handshake bundle for the multi-cycle ALU.
//   master: drives in_valid, a, b, op, out_ready; observes in_ready and the result.
//   slave : the ALU; drives in_ready, out_valid, y and the NZCV flags.
interface alu_mc_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             z;
    logic             n;
    logic             c;
    logic             v;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, y, z, n, c, v
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, y, z, n, c, v
    );
endinterface

// File: rtl/alu_mc.sv
// alu_mc -- multi-cycle execute-stage ALU with NZCV flags.
//   clk, rst : clock, asynchronous active-high reset.
//   bus      : alu_mc_if.slave; operand beat (in_valid/in_ready, a, b, op)
//              and result beat (out_valid/out_ready, y, z, n, c, v).
// Single-cycle ops are computed directly from the bus in the accept cycle
// and registered into the result. MUL runs a shift-add loop, one multiplier
// bit per cycle for WIDTH cycles; the last iteration loads the result.
module alu_mc #(
    parameter  int WIDTH = 64,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     rst,
    alu_mc_if.slave  bus
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_ORR = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_LSL = 4'b0011;
    localparam logic [3:0] OP_LSR = 4'b0100;
    localparam logic [3:0] OP_ASR = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_PSB = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_EOR = 4'b1001;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MULT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;

    // Single-cycle datapath, evaluated on the live bus operands.
    logic [SHW-1:0]   shamt, lsl_idx, lsr_idx;
    logic [WIDTH:0]   sum_add, sum_sub;
    logic [WIDTH-1:0] res_y;
    logic             res_c, res_v;
    logic [WIDTH-1:0] acc_nxt;

    always_comb begin
        shamt   = bus.b[SHW-1:0];
        // WIDTH is a power of two, so WIDTH-shamt wraps cleanly in SHW bits.
        lsl_idx = SHW'(0) - shamt;
        lsr_idx = shamt - SHW'(1);
        sum_add = {1'b0, bus.a} + {1'b0, bus.b};
        sum_sub = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);
        res_y   = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        case (bus.op)
            OP_AND: res_y = bus.a & bus.b;
            OP_ORR: res_y = bus.a | bus.b;
            OP_ADD: begin
                res_y = sum_add[WIDTH-1:0];
                res_c = sum_add[WIDTH];
                res_v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                        (sum_add[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                res_y = sum_sub[WIDTH-1:0];
                res_c = sum_sub[WIDTH];
                res_v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                        (sum_sub[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_NOR: res_y = ~(bus.a | bus.b);
            OP_PSB: res_y = bus.b;
            OP_EOR: res_y = bus.a ^ bus.b;
            OP_LSL: begin
                res_y = bus.a << shamt;
                res_c = (shamt != '0) && bus.a[lsl_idx];
            end
            OP_LSR: begin
                res_y = bus.a >> shamt;
                res_c = (shamt != '0) && bus.a[lsr_idx];
            end
            OP_ASR: begin
                res_y = $signed(bus.a) >>> shamt;
                res_c = (shamt != '0) && bus.a[lsr_idx];
            end
            default: res_y = '0;
        endcase
    end

    assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        y_d         = y_q;
        z_d         = z_q;
        n_d         = n_q;
        c_d         = c_q;
        v_d         = v_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    if (bus.op == OP_MUL) begin
                        mcand_d  = bus.a;
                        mplier_d = bus.b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = S_MULT;
                    end else begin
                        y_d         = res_y;
                        z_d         = (res_y == '0);
                        n_d         = res_y[WIDTH-1];
                        c_d         = res_c;
                        v_d         = res_v;
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end
                end
            end
            S_MULT: begin
                acc_d    = acc_nxt;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SHW'(1);
                if (cnt_q == SHW'(WIDTH-1)) begin
                    y_d         = acc_nxt;
                    z_d         = (acc_nxt == '0);
                    n_d         = acc_nxt[WIDTH-1];
                    c_d         = 1'b0;
                    v_d         = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            z_q         <= z_d;
            n_q         <= n_d;
            c_q         <= c_d;
            v_q         <= v_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    // Held low through reset so nothing is accepted before the first clean edge.
    assign bus.in_ready  = (state_q == S_IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.z         = z_q;
    assign bus.n         = n_q;
    assign bus.c         = c_q;
    assign bus.v         = v_q;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc -- bench for alu_mc: directed cases, multiply timing, backpressure,
// reset aborts, back-to-back throughput and randomized ops against a model.
module tb_alu_mc;
    localparam int W = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(W)) bus ();
    alu_mc #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: {y, z, n, c, v} from the architectural rules.
    function automatic logic [67:0] model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] y;
        logic c, v;
        int sh;
        sh = int'(b % 64);
        y = '0; c = 1'b0; v = 1'b0;
        case (op)
            4'b0000: y = a & b;
            4'b0001: y = a | b;
            4'b0010: begin y = a + b; c = (y < a); v = (a[63] == b[63]) && (y[63] != a[63]); end
            4'b0110: begin y = a - b; c = (a >= b); v = (a[63] != b[63]) && (y[63] != a[63]); end
            4'b1100: y = ~(a | b);
            4'b0111: y = b;
            4'b1001: y = a ^ b;
            4'b0011: begin y = a << sh; if (sh != 0) c = a[64-sh]; end
            4'b0100: begin y = a >> sh; if (sh != 0) c = a[sh-1]; end
            4'b0101: begin y = $signed(a) >>> sh; if (sh != 0) c = a[sh-1]; end
            4'b1000: y = a * b;
            default: y = '0;
        endcase
        return {y, (y == 64'd0), y[63], c, v};
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom % 6)
            0: return 64'd0;
            1: return {64{1'b1}};
            2: return 64'h8000_0000_0000_0000;
            3: return 64'($urandom % 80);
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a beat and hold it until accepted (bounded); ok=0 on timeout.
    task automatic send(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, output bit ok);
        bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (bus.in_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        bus.a = {$urandom, $urandom};
        bus.b = {$urandom, $urandom};
        bus.op = 4'($urandom);
    endtask

    // Cycles from the accept edge until out_valid is seen (1 = next cycle).
    task automatic wait_out(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0; bus.out_ready = 1'b1;
        rst = 1'b1;
        tick(); tick();
        n_checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b00) begin
            n_fail++; $display("FAIL reset_hs: got valid/ready %b exp 00", {bus.out_valid, bus.in_ready});
        end
        n_checks++;
        if ({bus.y, bus.z, bus.n, bus.c, bus.v} !== 68'd0) begin
            n_fail++; $display("FAIL reset_res: got %h exp 0", {bus.y, bus.z, bus.n, bus.c, bus.v});
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready: got %b exp 1", bus.in_ready);
        end
    endtask

    task automatic test_directed();
        logic [3:0]  ops [10] = '{4'b0010, 4'b0110, 4'b0110, 4'b0011, 4'b0101,
                                  4'b1111, 4'b0000, 4'b0100, 4'b0011, 4'b1100};
        logic [63:0] as  [10] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd5, 64'd3, 64'h8000_0000_0000_0001,
                                  64'h8000_0000_0000_0000, 64'h1234, 64'hF0, 64'd5, 64'd3, 64'h0F0F};
        logic [63:0] bs  [10] = '{64'd1, 64'd5, 64'd5, 64'd1, 64'h43, 64'h5678, 64'h3C, 64'd64, 64'd63, 64'hF0F0};
        logic [63:0] ys  [10] = '{64'h8000_0000_0000_0000, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2,
                                  64'hF000_0000_0000_0000, 64'd0, 64'h30, 64'd5,
                                  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_0000};
        logic [3:0]  fs  [10] = '{4'b0101, 4'b1010, 4'b0100, 4'b0010, 4'b0100,
                                  4'b1000, 4'b0000, 4'b0000, 4'b0110, 4'b0100};
        bit ok;
        int lat;
        for (int i = 0; i < 10; i++) begin
            send(ops[i], as[i], bs[i], ok);
            wait_out(lat);
            n_checks++;
            if (!ok || lat != 1) begin
                n_fail++; $display("FAIL dir%0d_latency: got ok=%0d lat=%0d exp lat=1", i, ok, lat);
            end
            n_checks++;
            if ({bus.y, bus.z, bus.n, bus.c, bus.v} !== {ys[i], fs[i]}) begin
                n_fail++; $display("FAIL dir%0d_result: got %h/%b exp %h/%b", i, bus.y,
                                   {bus.z, bus.n, bus.c, bus.v}, ys[i], fs[i]);
            end
            tick();
        end
    endtask

    task automatic test_mul();
        bit ok;
        bit ready_seen;
        int lat;
        send(4'b1000, 64'h1_0000_0003, 64'h1_0000_0005, ok);
        lat = 1;
        ready_seen = 1'b0;
        while (!bus.out_valid && lat < 200) begin
            if (bus.in_ready) ready_seen = 1'b1;
            tick();
            lat++;
        end
        if (bus.in_ready) ready_seen = 1'b1;
        n_checks++;
        if (!ok || lat != 65) begin
            n_fail++; $display("FAIL mul_latency: got ok=%0d lat=%0d exp 65", ok, lat);
        end
        n_checks++;
        if (ready_seen) begin
            n_fail++; $display("FAIL mul_in_ready: got in_ready high during multiply exp low");
        end
        n_checks++;
        if ({bus.y, bus.z, bus.n, bus.c, bus.v} !== {64'h0000_0008_0000_000F, 4'b0000}) begin
            n_fail++; $display("FAIL mul_result: got %h/%b exp 000000080000000f/0000", bus.y,
                               {bus.z, bus.n, bus.c, bus.v});
        end
        tick();
        n_checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL mul_retire: got valid/ready %b exp 01", {bus.out_valid, bus.in_ready});
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit bad;
        int lat;
        logic [63:0] a1, b1, a2, b2;
        logic [67:0] held;
        a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
        a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom};
        bus.out_ready = 1'b0;
        send(4'b0010, a1, b1, ok);
        wait_out(lat);
        n_checks++;
        if (!ok || lat != 1 || {bus.y, bus.z, bus.n, bus.c, bus.v} !== model(4'b0010, a1, b1)) begin
            n_fail++; $display("FAIL bp_first: got lat=%0d %h exp lat=1 %h", lat,
                               {bus.y, bus.z, bus.n, bus.c, bus.v}, model(4'b0010, a1, b1));
        end
        held = model(4'b0010, a1, b1);
        bus.op = 4'b1001; bus.a = a2; bus.b = b2; bus.in_valid = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                {bus.y, bus.z, bus.n, bus.c, bus.v} !== held) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++; $display("FAIL bp_hold: got %h valid=%b ready=%b exp %h held", {bus.y, bus.z, bus.n,
                               bus.c, bus.v}, bus.out_valid, bus.in_ready, held);
        end
        bus.out_ready = 1'b1;
        tick();
        n_checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL bp_retire: got valid/ready %b exp 01", {bus.out_valid, bus.in_ready});
        end
        tick();
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || {bus.y, bus.z, bus.n, bus.c, bus.v} !== model(4'b1001, a2, b2)) begin
            n_fail++; $display("FAIL bp_pending: got valid=%b %h exp 1 %h", bus.out_valid,
                               {bus.y, bus.z, bus.n, bus.c, bus.v}, model(4'b1001, a2, b2));
        end
        tick();
    endtask

    task automatic test_reset_abort();
        bit ok;
        int lat;
        send(4'b1000, {$urandom, $urandom} | 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, ok);
        repeat (19) tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.out_valid, bus.in_ready, bus.y} !== 66'd0) begin
            n_fail++; $display("FAIL rst_mult: got valid=%b ready=%b y=%h exp 0", bus.out_valid, bus.in_ready, bus.y);
        end
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_mult_no_result: got out_valid=%b exp 0", bus.out_valid);
        end
        send(4'b0000, 64'hF0, 64'h3C, ok);
        wait_out(lat);
        n_checks++;
        if (!ok || lat != 1 || bus.y !== 64'h30) begin
            n_fail++; $display("FAIL rst_and_after: got lat=%0d y=%h exp lat=1 y=30", lat, bus.y);
        end
        tick();
        // Reset while a result is waiting in DONE.
        bus.out_ready = 1'b0;
        send(4'b0001, 64'h5, 64'hA0, ok);
        wait_out(lat);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.out_valid, bus.y} !== 65'd0) begin
            n_fail++; $display("FAIL rst_done: got valid=%b y=%h exp 0", bus.out_valid, bus.y);
        end
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0]  op [5];
        logic [63:0] a [5], b [5];
        bit bad;
        for (int k = 0; k < 5; k++) begin
            op[k] = 4'b0010 + 4'(k % 2) * 4'b0100;   // alternate ADD / SUB
            a[k] = pick(); b[k] = pick();
        end
        bad = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.op = op[k]; bus.a = a[k]; bus.b = b[k];
            tick();
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                {bus.y, bus.z, bus.n, bus.c, bus.v} !== model(op[k], a[k], b[k])) begin
                bad = 1'b1;
                $display("FAIL b2b_beat%0d: got valid=%b %h exp 1 %h", k, bus.out_valid,
                         {bus.y, bus.z, bus.n, bus.c, bus.v}, model(op[k], a[k], b[k]));
            end
            bus.op = op[k+1]; bus.a = a[k+1]; bus.b = b[k+1];
            tick();
            if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
                bad = 1'b1;
                $display("FAIL b2b_gap%0d: got valid/ready %b exp 01", k, {bus.out_valid, bus.in_ready});
            end
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (bad) n_fail++;
    endtask

    task automatic test_random();
        bit ok;
        int lat, stall;
        logic [3:0]  op;
        logic [63:0] a, b;
        logic [67:0] exp_r;
        for (int i = 0; i < 250; i++) begin
            op = ($urandom % 10 == 0) ? 4'b1000 : 4'($urandom);
            a = pick(); b = pick();
            exp_r = model(op, a, b);
            stall = $urandom % 3;
            bus.out_ready = (stall == 0);
            send(op, a, b, ok);
            wait_out(lat);
            n_checks++;
            if (!ok || lat != ((op == 4'b1000) ? 65 : 1) || {bus.y, bus.z, bus.n, bus.c, bus.v} !== exp_r) begin
                n_fail++; $display("FAIL rand%0d op=%b a=%h b=%h: got lat=%0d %h exp %h", i, op, a, b, lat,
                                   {bus.y, bus.z, bus.n, bus.c, bus.v}, exp_r);
            end
            repeat (stall) tick();
            if (stall != 0) begin
                n_checks++;
                if (bus.out_valid !== 1'b1 || {bus.y, bus.z, bus.n, bus.c, bus.v} !== exp_r) begin
                    n_fail++; $display("FAIL rand%0d_stall: got valid=%b %h exp 1 %h", i, bus.out_valid,
                                       {bus.y, bus.z, bus.n, bus.c, bus.v}, exp_r);
                end
            end
            bus.out_ready = 1'b1;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mul();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised execute-stage ALU for the ARMv8 datapath, replacing the purely combinational ALU. It adds XOR, logical and arithmetic shifts, and an iterative multiply, and produces full NZCV flags. Operands and results move over valid/ready handshakes, so the pipeline can stall on the multi-cycle multiply. The opcode encodings of the existing ALU are kept unchanged.

## Interface
Parameters:
- WIDTH, 64, operand/result width; must be a power of two, at least 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  ALU can accept a beat.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; for shifts, b[SHW-1:0] is the shift amount.
- op  in  4  operation select.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result.
- y  out  WIDTH  result.
- z, n, c, v  out  1 each  flags of the result in y.

## Operation
- Opcodes:
  - 0000 AND
  - 0001 ORR
  - 0010 ADD
  - 0110 SUB (a-b)
  - 1100 NOR
  - 0111 PASS B
  - 1001 EOR
  - 0011 LSL
  - 0100 LSR
  - 0101 ASR
  - 1000 MUL (low WIDTH bits of a*b, unsigned = signed low half)
- Any other opcode: y=0, z=1, n=c=v=0, single-cycle completion.
- A beat is accepted when in_valid && in_ready. a, b and op are captured; later input changes have no effect.
- States:
  - IDLE: in_ready=1. On accept: MUL goes to MULT; all other ops compute the result and go to DONE.
  - MULT: shift-add, one multiplier bit per cycle, WIDTH iterations. After the last iteration, load y and go to DONE.
  - DONE: out_valid=1; y and flags are held stable. Go to IDLE on out_ready. No new beat is accepted in DONE.
- Arithmetic:
  - ADD/SUB use a (WIDTH+1)-bit sum. SUB is a + ~b + 1.
  - z = (y==0); n = y[WIDTH-1].
  - c:
    - ADD: carry out.
    - SUB: carry out, i.e. 1 when a >= b unsigned (ARM no-borrow convention).
    - LSL: last bit shifted out, a[WIDTH-shamt].
    - LSR/ASR: a[shamt-1].
    - Shift amount 0: c=0.
    - All other ops: 0.
  - v: signed overflow for ADD/SUB; 0 for every other op.
  - ASR fills with a[WIDTH-1]. Shift amount is b mod WIDTH; upper bits of b are ignored.
  - MUL: c=v=0. Product overflow is discarded silently.

## Timing
- Reset, asynchronous:
  - state=IDLE, out_valid=0, y=0, z=n=c=v=0.
  - in_ready=0 while rst is high, then 1 in the first cycle after release.
- Latency, counted from the accept edge:
  - Non-MUL ops: out_valid high in the next cycle (1 cycle).
  - MUL: out_valid high WIDTH+1 cycles after accept.
- Throughput:
  - Non-MUL, with out_ready held high: one beat every 2 cycles (accept, DONE, accept...).
  - MUL: one per WIDTH+2 cycles.
- out_valid, once high, stays high with y and flags unchanged until out_ready is sampled high.
- in_ready is low in MULT and DONE. An in_valid presented there is held off, not dropped.
- Reset asserted mid-MULT or in DONE aborts the operation. The result is never presented and out_valid falls immediately.
- in_valid and out_ready high together in DONE: the result is retired and the new beat is accepted on the following cycle, from IDLE.

## Test plan
- Reset, then ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1. Expect:
  - one cycle later, out_valid=1, y=0x8000_0000_0000_0000;
  - n=1, v=1, c=0, z=0.
- SUB a=5, b=5. Expect y=0, z=1, c=1, v=0. Then SUB a=3, b=5: y=0xFFFF_FFFF_FFFF_FFFE, n=1, c=0.
- LSL a=0x8000_0000_0000_0001, b=1. Expect y=2, c=1.
  - ASR a=0x8000_0000_0000_0000, b=0x43 (amount 3): y=0xF000_0000_0000_0000, c=0.
- MUL a=0x1_0000_0003, b=0x1_0000_0005. Expect:
  - in_ready low for 65 cycles;
  - out_valid exactly 65 cycles after accept;
  - y=0x0000_0008_0000_000F;
  - c=v=0.
- Hold out_ready=0 for 10 cycles after a result. Expect y and flags stable and in_ready=0 throughout; a pending in_valid is accepted only after the retire.
- Assert rst 20 cycles into a MUL. Expect out_valid=0 and y=0 immediately, and a following AND a=0xF0, b=0x3C returns y=0x30 after 1 cycle. Opcode 1111 returns y=0, z=1.
